// File: rtl/adc_req_arbiter.sv
// Round-robin arbiter sharing one ADC conversion engine between two SPI front-ends.
// Adds mux settling on channel change, times out a missing done, routes result to the owner.
module adc_req_arbiter #(
  parameter int CHAN_W         = 3,
  parameter int DATA_W         = 12,
  parameter int SETTLE_CYCLES  = 36,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CHAN_W-1:0] req0_chan,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic [CHAN_W-1:0] req1_chan,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CHAN_W-1:0] adc_chan,
  output logic              adc_start,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              busy
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, START, WAIT, RESP} state_t;

  state_t              state_reg, state_next;
  logic                ptr_reg;
  logic                owner_reg;
  logic [CHAN_W-1:0]   adc_chan_reg;
  logic [CHAN_W-1:0]   last_chan_reg;
  logic                last_chan_valid_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                rsp_err_reg;

  logic                grant;
  logic                accept;
  logic [CHAN_W-1:0]   req_chan;
  logic                chan_change;
  logic                settle_last;
  logic                timeout_hit;

  // Pointer only breaks ties; a lone requester is always granted.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ptr_reg;
    else if (req1_valid)          grant = 1'b1;
    accept      = (state_reg == IDLE) && (req0_valid || req1_valid);
    req_chan    = grant ? req1_chan : req0_chan;
    chan_change = !last_chan_valid_reg || (req_chan != last_chan_reg);
    settle_last = (cnt_reg == CNT_W'(1));
    timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = chan_change ? SETTLE : START;
      SETTLE:  if (settle_last) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (adc_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    adc_start  = (state_reg == START);
    rsp0_valid = (state_reg == RESP) && !owner_reg;
    rsp1_valid = (state_reg == RESP) && owner_reg;
    busy       = (state_reg != IDLE);
    adc_chan   = adc_chan_reg;
    rsp_data   = rsp_data_reg;
    rsp_err    = rsp_err_reg;
  end

  // One counter serves both the settle countdown and the done timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg             <= 1'b0;
      owner_reg           <= 1'b0;
      adc_chan_reg        <= '0;
      last_chan_reg       <= '0;
      last_chan_valid_reg <= 1'b0;
      cnt_reg             <= '0;
      rsp_data_reg        <= '0;
      rsp_err_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg    <= grant;
            adc_chan_reg <= req_chan;
            cnt_reg      <= CNT_W'(SETTLE_CYCLES);
          end
        end
        SETTLE: cnt_reg <= cnt_reg - CNT_W'(1);
        START: begin
          last_chan_reg       <= adc_chan_reg;
          last_chan_valid_reg <= 1'b1;
          cnt_reg             <= '0;
        end
        WAIT: begin
          if (adc_done) begin
            rsp_data_reg <= adc_data;
            rsp_err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            // The mux state is unknown after a lost conversion, so force a fresh settle.
            rsp_data_reg        <= '0;
            rsp_err_reg         <= 1'b1;
            last_chan_valid_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        RESP: ptr_reg <= ~owner_reg;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Scoreboard bench for adc_req_arbiter: stimulus pushes expected responses,
// a negedge monitor checks accepts, start latency and responses against them.
module tb_adc_req_arbiter;
  localparam int SETTLE  = 36;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0]  req0_chan = '0, req1_chan = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [11:0] rsp_data;
  logic        rsp_err;
  logic [2:0]  adc_chan;
  logic        adc_start;
  logic        adc_done = 1'b0;
  logic [11:0] adc_data = '0;
  logic        busy;

  adc_req_arbiter #(.CHAN_W(3), .DATA_W(12), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_chan(req0_chan), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_chan(req1_chan), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .adc_chan(adc_chan), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [2:0]  chan;
    logic [11:0] data;
    logic        err;
    logic        settle;
    int          delay;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_count = 0;
  int   acc_cyc = 0;
  int   start_cyc = 0;
  int   done_cycle = -1;
  logic [11:0] done_val = '0;
  logic spur = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic port, input logic [2:0] chan, input logic [11:0] data,
                      input int delay, input logic settle);
    exp_t e;
    e.port = port; e.chan = chan; e.data = data; e.delay = delay;
    e.err = (delay < 0); e.settle = settle;
    q.push_back(e);
  endtask

  // Called at posedge+1; holds valid through the accept edge then drops it.
  task automatic issue(input logic port, input logic [2:0] chan, output int waited);
    waited = 0;
    if (port) begin req1_valid = 1'b1; req1_chan = chan; end
    else      begin req0_valid = 1'b1; req0_chan = chan; end
    #1;
    while (!(port ? req1_ready : req0_ready) && waited < 3000) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 3000) check("ready_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) begin
      check("rsp_timeout", 32'(q.size()), 32'(0));
      q.delete();
    end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_count < target && n < 3000) begin @(posedge clk); #1; n++; end
    if (acc_count < target) check("accept_timeout", 32'(acc_count), 32'(target));
  endtask

  // ADC model: done after the scheduled delay, plus optional spurious pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        done_cycle = -1; adc_done = 1'b0; adc_data = 12'h3C3;
      end else begin
        if (adc_start && q.size() != 0 && q[0].delay >= 0) begin
          done_cycle = cyc + q[0].delay;
          done_val   = q[0].data;
        end
        if (cyc == done_cycle) begin
          adc_done = 1'b1; adc_data = done_val; done_cycle = -1;
        end else if (spur) begin
          adc_done = 1'b1; adc_data = 12'h5A5; spur = 1'b0;
        end else begin
          adc_done = 1'b0; adc_data = 12'h3C3;
        end
      end
    end
  end

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req0_ready && req1_ready) check("dual_ready", 32'(1), 32'(0));
        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          acc_count++;
          acc_cyc = cyc;
          check("accept_expected", 32'(q.size() != 0), 32'(1));
          if (q.size() != 0) begin
            check("accept_port", 32'(req1_ready), 32'(q[0].port));
            check("accept_chan", 32'(req1_ready ? req1_chan : req0_chan), 32'(q[0].chan));
          end
        end
        if (adc_start) begin
          start_cyc = cyc;
          check("start_expected", 32'(q.size() != 0), 32'(1));
          check("start_busy", 32'(busy), 32'(1));
          if (q.size() != 0) begin
            check("start_chan", 32'(adc_chan), 32'(q[0].chan));
            check("start_latency", 32'(cyc - acc_cyc), 32'(q[0].settle ? SETTLE + 1 : 1));
          end
        end
        if (rsp0_valid || rsp1_valid) begin
          check("rsp_single", 32'(rsp0_valid && rsp1_valid), 32'(0));
          check("rsp_expected", 32'(q.size() != 0), 32'(1));
          if (q.size() != 0) begin
            e = q.pop_front();
            check("rsp_port", 32'(rsp1_valid), 32'(e.port));
            check("rsp_data", 32'(rsp_data), 32'(e.err ? 12'h000 : e.data));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_latency", 32'(cyc - start_cyc), 32'(e.err ? TIMEOUT + 1 : e.delay + 1));
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_adc_chan"}, 32'(adc_chan), 32'(0));
    check({tag, "_adc_start"}, 32'(adc_start), 32'(0));
    check({tag, "_rsp_valid"}, 32'({rsp0_valid, rsp1_valid}), 32'(0));
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'(0));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
  endtask

  initial begin
    int w;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;

    // First request after reset settles; immediate repeat on same channel does not.
    push(1'b0, 3'd2, 12'hABC, 10, 1'b1); issue(1'b0, 3'd2, w);
    check("first_ready_wait", 32'(w), 32'(0));
    wait_empty();
    push(1'b0, 3'd2, 12'h456, 5, 1'b0); issue(1'b0, 3'd2, w);
    check("back_to_back_ready_wait", 32'(w), 32'(0));
    wait_empty();

    // Timeout, then same channel must settle again, then done on the final WAIT cycle.
    push(1'b1, 3'd3, 12'h000, -1, 1'b1); issue(1'b1, 3'd3, w); wait_empty();
    push(1'b1, 3'd3, 12'h123, 7, 1'b1);  issue(1'b1, 3'd3, w); wait_empty();
    push(1'b1, 3'd3, 12'h7E5, TIMEOUT, 1'b0); issue(1'b1, 3'd3, w); wait_empty();

    // Both ports held: grants alternate starting from port0.
    push(1'b0, 3'd1, 12'h111, 3, 1'b1);
    push(1'b1, 3'd5, 12'h555, 3, 1'b1);
    push(1'b0, 3'd1, 12'h1A1, 3, 1'b1);
    push(1'b1, 3'd5, 12'h5E5, 3, 1'b1);
    w = acc_count;
    req0_chan = 3'd1; req1_chan = 3'd5; req0_valid = 1'b1; req1_valid = 1'b1;
    wait_acc(w + 3); req0_valid = 1'b0;
    wait_acc(w + 4); req1_valid = 1'b0;
    wait_empty();

    // Spurious done in IDLE must not disturb anything.
    spur = 1'b1;
    repeat (5) @(posedge clk); #1;
    check("idle_spur_busy", 32'(busy), 32'(0));
    check("idle_spur_rsp_data", 32'(rsp_data), 32'(12'h5E5));

    // Spurious done during SETTLE is ignored; real result still delivered.
    push(1'b0, 3'd6, 12'h2D2, 4, 1'b1); issue(1'b0, 3'd6, w);
    repeat (5) @(posedge clk); #1;
    spur = 1'b1;
    wait_empty();

    // Reset during WAIT aborts silently; same channel afterwards settles in full.
    push(1'b0, 3'd6, 12'h000, -1, 1'b0); issue(1'b0, 3'd6, w);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_outputs("midreset");
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    push(1'b0, 3'd6, 12'h9F0, 6, 1'b1); issue(1'b0, 3'd6, w);
    check("post_reset_ready_wait", 32'(w), 32'(0));
    wait_empty();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_req_arbiter.md
Name: adc_req_arbiter

Overview:
Shares the single ADC conversion engine between the two SPI host front-ends (SPI1 and SPI2). Each front-end posts a channel-conversion request and receives the result. The arbiter grants requests round-robin and inserts a mux settling delay when the channel changes. It pulses the ADC start, waits for done with a timeout, and routes the result or an error back to the owning port. It sits between the two SPI slave blocks and the ADC sequencer in the top level, on the same clock.

Parameters:
CHAN_W, 3, width of ADC channel select
DATA_W, 12, width of ADC result
SETTLE_CYCLES, 36, clk cycles of mux settling before start on channel change (1 us at 36 MHz); must be >=1
TIMEOUT_CYCLES, 1024, max clk cycles waiting for adc_done before error; must be >=1

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-high reset
req0_valid  in  1  SPI1 front-end conversion request
req0_chan  in  CHAN_W  SPI1 requested channel, stable while req0_valid
req0_ready  out  1  SPI1 request accepted this cycle
rsp0_valid  out  1  one-cycle pulse: SPI1 result available
req1_valid  in  1  SPI2 front-end conversion request
req1_chan  in  CHAN_W  SPI2 requested channel
req1_ready  out  1  SPI2 request accepted this cycle
rsp1_valid  out  1  one-cycle pulse: SPI2 result available
rsp_data  out  DATA_W  result, shared by both ports, held until next response
rsp_err  out  1  1 = timeout; held with rsp_data
adc_chan  out  CHAN_W  channel to ADC mux, registered
adc_start  out  1  one-cycle conversion start pulse
adc_done  in  1  one-cycle conversion complete pulse
adc_data  in  DATA_W  result, valid when adc_done=1
busy  out  1  high in any state except IDLE (for status LED)

Behaviour:
- Reset (async assert, sync to clk on release):
  - State IDLE. All outputs 0. adc_chan=0.
  - Priority pointer=port0. last_chan_valid=0. Counters 0.
- States: IDLE, SETTLE, START, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: (state==IDLE) && grant==N.
  - grant = the only valid port, or the pointer port when both are valid. No ready when no valid.
  - On accept: latch owner and chan; adc_chan<=chan on the next edge.
  - If last_chan_valid=0 or chan!=last_chan: go to SETTLE with counter loaded. Else go to START.
  - Accepted request is never re-accepted. The front-end drops valid or presents a new request after ready.
- SETTLE: remains exactly SETTLE_CYCLES cycles, then START.
- START: adc_start=1 for exactly one cycle; last_chan<=chan; last_chan_valid<=1; go to WAIT with timeout counter cleared.
- WAIT:
  - On adc_done: rsp_data<=adc_data, rsp_err<=0, go to RESP. adc_done in the same cycle as the timeout wins.
  - After TIMEOUT_CYCLES cycles with no done: rsp_data<=0, rsp_err<=1, last_chan_valid<=0, go to RESP.
- RESP: rspN_valid=1 for the owner only, one cycle. Pointer<=other port. Go to IDLE.
- Latency:
  - Accept edge to adc_start: 1 cycle on the same channel, 1+SETTLE_CYCLES on a channel change.
  - adc_done at cycle t gives rspN_valid at t+1.
  - Earliest next accept is the cycle after RESP.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1. Starting with port0 after reset.
- adc_done outside WAIT is ignored; no state or output change.
- Reset mid-operation: immediate abort to reset values. No rsp pulse is generated for the aborted request.
- Counters are sized to clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1) and must not wrap.

Test Plan:
- After reset: req0 chan=2, ADC model returns done 10 cycles after start with data 0xABC.
  -> ready0 in cycle 0, adc_start exactly once 37 cycles after accept with adc_chan=2, rsp0_valid 1 cycle after done, rsp_data=0xABC, rsp_err=0, rsp1_valid never.
- Second req0 with chan=2 immediately after the first.
  -> no settle: adc_start 1 cycle after accept; same result path.
- req0 and req1 asserted together and held, chan 1 and 5.
  -> grant order 0,1,0,1; adc_chan toggles 1/5; each start preceded by 36 settle cycles; responses on the matching rspN_valid only.
- req1 chan=3 with the ADC model never asserting done.
  -> rsp1_valid exactly 1024 cycles after entering WAIT, rsp_data=0, rsp_err=1; a following chan=3 request settles again.
- Done at the timeout boundary: adc_done on the final WAIT cycle.
  -> rsp_err=0 with the data. Spurious adc_done pulses in IDLE and SETTLE: no state change, no rsp.
- Assert rst during WAIT.
  -> all outputs 0 asynchronously, no rsp pulse. Next request on the same channel incurs the full settle.
